register_file_2r1w: RTL and testbench
=====================================

// Module: register_file_2r1w
// PURPOSE
//  - Two-read/one-write register bank downstream of mux_2to1: the mux output drives wd; rd1/rd2 feed ALU operand muxes.
//  - 2**ADDR_W entries of WIDTH bits; writes synchronous, reads combinational; top address aliases an external PC value.
//  - Used as the lab datapath storage element; sized to match the 8-bit mux datapath by default.
// PARAMETERS
//  - WIDTH   8  data width of every entry, wd, rd1, rd2, pc_in
//  - ADDR_W  4  address width; NREG = 2**ADDR_W entries; PC alias at index NREG-1
// PORTS
//  - clk     in   1       single clock; all state updates on rising edge
//  - reset   in   1       synchronous, active-high; sampled on rising edge of clk
//  - we      in   1       write enable
//  - wa      in   ADDR_W  write address
//  - wd      in   WIDTH   write data (from mux_2to1 out)
//  - ra1     in   ADDR_W  read address, port 1
//  - ra2     in   ADDR_W  read address, port 2
//  - pc_in   in   WIDTH   value returned for reads of index NREG-1
//  - rd1     out  WIDTH   read data, port 1
//  - rd2     out  WIDTH   read data, port 2
//  - wr_cnt  out  8       count of committed writes, wraps 255->0
// BEHAVIOUR
//  - Reset: on rising clk with reset=1, entries 0..NREG-2 <= 0, wr_cnt <= 0; reset beats we in the same cycle.
//  - Reset is synchronous only: asserting it mid-cycle changes nothing until the next rising edge.
//  - Write: rising clk, reset=0, we=1, wa!=NREG-1 -> mem[wa] <= wd, wr_cnt <= wr_cnt+1 (8-bit, wraps).
//  - Write to wa=NREG-1 is dropped: no state change, wr_cnt unchanged; the PC is owned externally.
//  - we=0: no entry or wr_cnt change; wa/wd ignored.
//  - Read: fully combinational, zero latency. rdN = pc_in if raN=NREG-1, else mem[raN].
//  - Both ports may read the same address in the same cycle; both return identical data.
//  - Read-during-write (raN==wa, we=1) without bypass: rdN shows the old value until the edge, then the new value.
//  - Outputs after reset: rd1/rd2 = 0 for any address except NREG-1, where they equal pc_in.
//  - X/Z on wa with we=1 is a bench error; the RTL does not guard it.
//  - No state machine; the sole sequential state is mem[0..NREG-2] and wr_cnt.
// CONFIGURATION
//  - Macro: REGFILE_WRITE_BYPASS_EN
//  - Defined: if we=1, reset=0, wa!=NREG-1 and raN==wa, rdN = wd combinationally in the same cycle (write-through).
//    Bypass never applies to index NREG-1 (pc_in still wins) and is suppressed while reset=1.
//  - Undefined: no forwarding; read-during-write returns the stored value (see BEHAVIOUR).
//  - Storage update, wr_cnt and reset behaviour are identical in both builds.
// TESTING
//  - Reset: write 8'hA5 to r3, then reset=1 for 1 clk -> rd1(ra1=3)=8'h00, wr_cnt=0.
//  - Write/read: we=1 wa=2 wd=8'h3C, clk; then ra1=2 ra2=2 -> rd1=rd2=8'h3C, wr_cnt=1.
//  - PC alias: pc_in=8'h48, we=1 wa=15 wd=8'hFF, clk; ra1=15 -> rd1=8'h48, wr_cnt unchanged.
//  - Reset priority: reset=1 and we=1 wa=5 wd=8'h77 in the same cycle -> rd1(ra1=5)=8'h00 after the edge.
//  - Read-during-write: r4=8'h11, we=1 wa=4 wd=8'h22, ra1=4 before the edge -> rd1=8'h11 (no bypass)
//    or 8'h22 (REGFILE_WRITE_BYPASS_EN); after the edge rd1=8'h22 in both builds.
//  - Counter wrap: 256 writes to r1 -> wr_cnt=0; last wd=8'h9E readable on rd2 with ra2=1.

Source files
------------

// File: rtl/register_file_2r1w.sv
// Two-read/one-write register bank. Writes are synchronous and reads are combinational.
// The top index aliases the external pc_in. Define REGFILE_WRITE_BYPASS_EN to get write-through reads.
module register_file_2r1w #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              we,
  input  logic [ADDR_W-1:0] wa,
  input  logic [WIDTH-1:0]  wd,
  input  logic [ADDR_W-1:0] ra1,
  input  logic [ADDR_W-1:0] ra2,
  input  logic [WIDTH-1:0]  pc_in,
  output logic [WIDTH-1:0]  rd1,
  output logic [WIDTH-1:0]  rd2,
  output logic [7:0]        wr_cnt
);

  localparam int NREG = 2 ** ADDR_W;
  localparam logic [ADDR_W-1:0] PC_IDX = ADDR_W'(NREG - 1);

  // Only NREG-1 physical entries: the top index is never stored here.
  logic [WIDTH-1:0] mem_q [NREG-1];
  logic [WIDTH-1:0] mem_d [NREG-1];
  logic [7:0]       wr_cnt_q;
  logic [7:0]       wr_cnt_d;
  logic             wr_en;

  assign wr_en = we && (wa != PC_IDX);

  always_comb begin
    mem_d    = mem_q;
    wr_cnt_d = wr_cnt_q;
    if (wr_en) begin
      mem_d[wa] = wd;
      wr_cnt_d  = wr_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q    <= '{default: '0};
      wr_cnt_q <= '0;
    end else begin
      mem_q    <= mem_d;
      wr_cnt_q <= wr_cnt_d;
    end
  end

  always_comb begin
    rd1 = '0;
    if (ra1 == PC_IDX) begin
      rd1 = pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
    end else if (wr_en && !reset && (ra1 == wa)) begin
      rd1 = wd;
`endif
    end else begin
      rd1 = mem_q[ra1];
    end
  end

  always_comb begin
    rd2 = '0;
    if (ra2 == PC_IDX) begin
      rd2 = pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
    end else if (wr_en && !reset && (ra2 == wa)) begin
      rd2 = wd;
`endif
    end else begin
      rd2 = mem_q[ra2];
    end
  end

  assign wr_cnt = wr_cnt_q;

endmodule

// File: tb/tb_register_file_2r1w.sv
// Bench for register_file_2r1w: directed vectors and a reference model of the register bank.
// The model is checked on every falling edge, and hand-computed literal values check the model itself.
module tb_register_file_2r1w;

  localparam int W = 8;
  localparam int A = 4;
  localparam int PC = 15;

  logic         clk = 1'b0;
  logic         reset;
  logic         we;
  logic [A-1:0] wa;
  logic [W-1:0] wd;
  logic [A-1:0] ra1;
  logic [A-1:0] ra2;
  logic [W-1:0] pc_in;
  logic [W-1:0] rd1;
  logic [W-1:0] rd2;
  logic [7:0]   wr_cnt;

  int tests_run = 0;
  int tests_failed = 0;
  bit check_en = 1'b0;

  logic [W-1:0] model_mem [16];
  logic [7:0]   model_cnt;

  register_file_2r1w #(.WIDTH(W), .ADDR_W(A)) dut (
    .clk(clk), .reset(reset), .we(we), .wa(wa), .wd(wd),
    .ra1(ra1), .ra2(ra2), .pc_in(pc_in),
    .rd1(rd1), .rd2(rd2), .wr_cnt(wr_cnt)
  );

  // clock
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %02h expected %02h at %0t", name, got, exp, $time);
    end
  endtask

  function automatic logic [W-1:0] model_rd(input logic [A-1:0] ra);
    if (int'(ra) == PC) return pc_in;
`ifdef REGFILE_WRITE_BYPASS_EN
    if (we && !reset && (int'(wa) != PC) && (ra == wa)) return wd;
`endif
    return model_mem[ra];
  endfunction

  // Advance one rising edge and apply the model's view of that edge. Inputs then change 1 time unit later.
  task automatic tick();
    @(posedge clk);
    if (reset) begin
      for (int i = 0; i < PC; i++) model_mem[i] = '0;
      model_cnt = 8'd0;
    end else if (we && int'(wa) != PC) begin
      model_mem[wa] = wd;
      model_cnt = model_cnt + 8'd1;
    end
    #1;
  endtask

  // scoreboard compare on every falling edge
  always @(negedge clk) begin
    if (check_en) begin
      check("rd1_model", rd1, model_rd(ra1));
      check("rd2_model", rd2, model_rd(ra2));
      check("wr_cnt_model", wr_cnt, model_cnt);
    end
  end

  initial begin
    for (int i = 0; i < 16; i++) model_mem[i] = '0;
    model_cnt = 8'd0;
    reset = 1'b1; we = 1'b0; wa = '0; wd = '0; ra1 = '0; ra2 = '0; pc_in = 8'h5A;
    tick(); tick();
    reset = 1'b0;
    check_en = 1'b1;
    #1;
    check("reset_rd1_r0", rd1, 8'h00);
    check("reset_cnt", wr_cnt, 8'h00);
    ra2 = 4'd15; #1;
    check("reset_rd2_pc", rd2, 8'h5A);

    // a written value is cleared by reset
    we = 1'b1; wa = 4'd3; wd = 8'hA5; tick();
    we = 1'b0; ra1 = 4'd3; #1;
    check("r3_written", rd1, 8'hA5);
    check("cnt_after_r3", wr_cnt, 8'h01);
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("r3_after_reset", rd1, 8'h00);
    check("cnt_after_reset", wr_cnt, 8'h00);

    // write then read the same entry on both ports
    we = 1'b1; wa = 4'd2; wd = 8'h3C; tick();
    we = 1'b0; ra1 = 4'd2; ra2 = 4'd2; #1;
    check("wr_rd1", rd1, 8'h3C);
    check("wr_rd2", rd2, 8'h3C);
    check("wr_cnt1", wr_cnt, 8'h01);

    // a write to the PC alias is dropped
    pc_in = 8'h48; we = 1'b1; wa = 4'd15; wd = 8'hFF; tick();
    we = 1'b0; ra1 = 4'd15; #1;
    check("pc_alias_rd1", rd1, 8'h48);
    check("pc_alias_cnt", wr_cnt, 8'h01);

    // reset wins over a write in the same cycle
    we = 1'b1; wa = 4'd5; wd = 8'h55; tick();
    reset = 1'b1; wa = 4'd5; wd = 8'h77; tick();
    reset = 1'b0; we = 1'b0; ra1 = 4'd5; #1;
    check("rst_prio_rd1", rd1, 8'h00);
    check("rst_prio_cnt", wr_cnt, 8'h00);

    // read during write
    we = 1'b1; wa = 4'd4; wd = 8'h11; tick();
    wd = 8'h22; ra1 = 4'd4; #1;
`ifdef REGFILE_WRITE_BYPASS_EN
    check("rdw_before", rd1, 8'h22);
`else
    check("rdw_before", rd1, 8'h11);
`endif
    tick();
    we = 1'b0; #1;
    check("rdw_after", rd1, 8'h22);

    // reset asserted between edges has no effect until the next rising edge
    @(negedge clk); reset = 1'b1; #1;
    check("midcycle_reset", rd1, 8'h22);
    reset = 1'b0;
    tick();
    check("midcycle_reset_cnt", wr_cnt, 8'h02);

    // directed sweep covering every address, same-address reads and the PC index
    for (int i = 0; i < 48; i++) begin
      we  = (i % 3) != 0;
      wa  = A'(i % 16);
      wd  = W'(i * 7 + 3);
      ra1 = A'((i + 5) % 16);
      ra2 = A'(i % 16);
      pc_in = W'(8'hC0 + i);
      tick();
    end

    // counter wrap
    reset = 1'b1; we = 1'b0; tick(); reset = 1'b0;
    for (int i = 0; i < 256; i++) begin
      we = 1'b1; wa = 4'd1; wd = (i == 255) ? 8'h9E : W'(i);
      tick();
      if (i == 254) check("cnt_255", wr_cnt, 8'hFF);
    end
    we = 1'b0; ra2 = 4'd1; #1;
    check("wrap_cnt", wr_cnt, 8'h00);
    check("wrap_rd2", rd2, 8'h9E);

    tick(); tick();
    check_en = 1'b0;
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
